// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter: arbitration states,
// read-owner tags and the memory geometry it is sized against.
package dmem_arbiter_pkg;

   localparam int DATA_MEM_NUM_LOG = 10;
   localparam int REG_DATA_W       = 32;
   localparam int STARVE_MAX_DEF   = 4;
   localparam int LOCK_MAX_DEF     = 16;

   typedef enum logic [1:0] {
      ST_ARB   = 2'd0,
      ST_LOCK  = 2'd1,
      ST_YIELD = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P    = 2'd1,
      OWN_L    = 2'd2
   } rd_owner_e;

   // Only a granted read earns a return slot; writes never produce one.
   function automatic rd_owner_e next_owner(input logic p_gnt, input logic p_we,
                                            input logic l_gnt, input logic l_we);
      rd_owner_e own;
      if (p_gnt && !p_we) begin
         own = OWN_P;
      end else if (l_gnt && !l_we) begin
         own = OWN_L;
      end else begin
         own = OWN_NONE;
      end
      return own;
   endfunction

endpackage

// File: rtl/dmem_rd_tag.sv
// One-cycle read-owner register: remembers who issued the read in flight and
// steers the synchronous memory read data back to that requester.
module dmem_rd_tag
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p_gnt,
   input  logic              p_we,
   input  logic              l_gnt,
   input  logic              l_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              p_rvalid,
   output logic [DATA_W-1:0] p_rdata,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata
);

   rd_owner_e owner_q;
   rd_owner_e owner_d;

   always_comb begin
      owner_d = next_owner(p_gnt, p_we, l_gnt, l_we);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   // Gating with rst drops the return of a read that was in flight when reset hit.
   assign p_rvalid = (owner_q == OWN_P) & ~rst;
   assign l_rvalid = (owner_q == OWN_L) & ~rst;
   assign p_rdata  = mem_rdata;
   assign l_rdata  = mem_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: fixed pipeline priority with a loader
// starvation guard, bounded loader burst lock, and routed read returns.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_W     = REG_DATA_W,
   parameter int ADDR_W     = DATA_MEM_NUM_LOG,
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p_req,
   input  logic              p_we,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic              p_gnt,
   output logic              p_rvalid,
   output logic [DATA_W-1:0] p_rdata,
   output logic              stall_o,
   input  logic              l_req,
   input  logic              l_we,
   input  logic              l_lock,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int LW = $clog2(LOCK_MAX + 1) + 1;
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [SW-1:0] STARVE_ONE = SW'(1);
   localparam logic [LW-1:0] LOCK_LIM   = LW'(LOCK_MAX);
   localparam logic [LW-1:0] LOCK_ONE   = LW'(1);

   arb_state_e    state_q,      state_d;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   logic [LW-1:0] lock_cnt_q,   lock_cnt_d;
   logic [LW-1:0] lock_cnt_inc;
   logic          starve_hit;

   assign starve_hit = (starve_cnt_q >= STARVE_LIM);

   always_comb begin
      p_gnt        = 1'b0;
      l_gnt        = 1'b0;
      state_d      = state_q;
      lock_cnt_d   = lock_cnt_q;
      lock_cnt_inc = lock_cnt_q + LOCK_ONE;
      case (state_q)
         ST_ARB: begin
            p_gnt = p_req & ~(l_req & starve_hit);
            l_gnt = ~p_gnt & l_req;
            if (l_gnt && l_lock) begin
               state_d    = ST_LOCK;
               lock_cnt_d = LOCK_ONE;
            end else begin
               lock_cnt_d = '0;
            end
         end
         ST_LOCK: begin
            // The entry grant already counted, so the limit is reached on the
            // grant that brings the post-increment count to LOCK_MAX.
            l_gnt = l_req;
            if (!l_lock) begin
               state_d    = ST_ARB;
               lock_cnt_d = '0;
            end else if (l_gnt && (lock_cnt_inc >= LOCK_LIM)) begin
               state_d    = ST_YIELD;
               lock_cnt_d = '0;
            end else if (l_gnt) begin
               lock_cnt_d = lock_cnt_inc;
            end else begin
               lock_cnt_d = lock_cnt_q;
            end
         end
         ST_YIELD: begin
            p_gnt      = p_req;
            state_d    = ST_ARB;
            lock_cnt_d = '0;
         end
         default: begin
            state_d    = ST_ARB;
            lock_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      if (!l_req || l_gnt) begin
         starve_cnt_d = '0;
      end else if (p_gnt && !starve_hit) begin
         starve_cnt_d = starve_cnt_q + STARVE_ONE;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   always_comb begin
      if (p_gnt) begin
         mem_we    = p_we;
         mem_addr  = p_addr;
         mem_wdata = p_wdata;
      end else if (l_gnt) begin
         mem_we    = l_we;
         mem_addr  = l_addr;
         mem_wdata = l_wdata;
      end else begin
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
      end
   end

   assign mem_en  = p_gnt | l_gnt;
   assign stall_o = p_req & ~p_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_ARB;
         starve_cnt_q <= '0;
         lock_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
      end
   end

   dmem_rd_tag #(
      .DATA_W (DATA_W)
   ) u_rd_tag (
      .clk       (clk),
      .rst       (rst),
      .p_gnt     (p_gnt),
      .p_we      (p_we),
      .l_gnt     (l_gnt),
      .l_we      (l_we),
      .mem_rdata (mem_rdata),
      .p_rvalid  (p_rvalid),
      .p_rdata   (p_rdata),
      .l_rvalid  (l_rvalid),
      .l_rdata   (l_rdata)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a per-cycle vector table plus hand-written
// lock, lock-hold and reset-mid-read sequences, against a behavioural memory.
module tb_dmem_arbiter;

   localparam int DW = 32;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          p_req, p_we, l_req, l_we, l_lock;
   logic [AW-1:0] p_addr, l_addr;
   logic [DW-1:0] p_wdata, l_wdata;
   logic          p_gnt, p_rvalid, stall_o, l_gnt, l_rvalid;
   logic [DW-1:0] p_rdata, l_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   int checks = 0;
   int errors = 0;

   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(4), .LOCK_MAX(16)) dut (
      .clk(clk), .rst(rst),
      .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata), .stall_o(stall_o),
      .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory: read data appears the cycle after issue.
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
   end

   typedef struct {
      logic          p_req, p_we;
      logic [AW-1:0] p_addr;
      logic [DW-1:0] p_wdata;
      logic          l_req, l_we, l_lock;
      logic [AW-1:0] l_addr;
      logic [DW-1:0] l_wdata;
      logic          e_pg, e_lg, e_prv, e_lrv;
      logic [DW-1:0] e_rdata;
   } vec_t;

   vec_t vecs [25];

   function automatic vec_t mk(input logic pr, input logic pw, input int pa, input int pd,
                               input logic lr, input logic lw, input logic lk, input int la,
                               input int ld, input logic epg, input logic elg,
                               input logic eprv, input logic elrv, input int erd);
      vec_t v;
      v.p_req = pr; v.p_we = pw; v.p_addr = AW'(pa); v.p_wdata = DW'(pd);
      v.l_req = lr; v.l_we = lw; v.l_lock = lk; v.l_addr = AW'(la); v.l_wdata = DW'(ld);
      v.e_pg = epg; v.e_lg = elg; v.e_prv = eprv; v.e_lrv = elrv; v.e_rdata = DW'(erd);
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      p_req = v.p_req; p_we = v.p_we; p_addr = v.p_addr; p_wdata = v.p_wdata;
      l_req = v.l_req; l_we = v.l_we; l_lock = v.l_lock; l_addr = v.l_addr; l_wdata = v.l_wdata;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t idle;
      logic          exp_l;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          ew;
      idle = mk(0,0,0,0, 0,0,0,0,0, 0,0,0,0,0);

      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      mem[5] = 32'h0000_1234;
      mem[3] = 32'h0000_AAAA;
      mem_rdata = '0;

      //            p_req we addr data  l_req we lock addr data   pg lg prv lrv rdata
      vecs[0]  = mk(0,0,0,0,            0,0,0,0,0,                0,0,0,0,0);
      vecs[1]  = mk(1,0,5,0,            0,0,0,0,0,                1,0,0,0,0);
      vecs[2]  = mk(0,0,0,0,            0,0,0,0,0,                0,0,1,0,32'h1234);
      vecs[3]  = mk(1,0,3,0,            0,0,0,0,0,                1,0,0,0,0);
      vecs[4]  = mk(0,0,0,0,            1,1,0,3,32'hBEEF,         0,1,1,0,32'hAAAA);
      vecs[5]  = mk(1,0,3,0,            0,0,0,0,0,                1,0,0,0,0);
      vecs[6]  = mk(0,0,0,0,            0,0,0,0,0,                0,0,1,0,32'hBEEF);
      vecs[7]  = mk(0,0,0,0,            1,0,0,5,0,                0,1,0,0,0);
      vecs[8]  = mk(0,0,0,0,            0,0,0,0,0,                0,0,0,1,32'h1234);
      vecs[9]  = mk(1,0,5,0,            1,0,0,3,0,                1,0,0,0,0);
      vecs[10] = mk(1,0,5,0,            1,0,0,3,0,                1,0,1,0,32'h1234);
      vecs[11] = mk(1,0,5,0,            1,0,0,3,0,                1,0,1,0,32'h1234);
      vecs[12] = mk(1,0,5,0,            1,0,0,3,0,                1,0,1,0,32'h1234);
      vecs[13] = mk(1,0,5,0,            1,0,0,3,0,                0,1,1,0,32'h1234);
      vecs[14] = mk(1,0,5,0,            1,0,0,3,0,                1,0,0,1,32'hBEEF);
      vecs[15] = mk(1,0,5,0,            1,0,0,3,0,                1,0,1,0,32'h1234);
      vecs[16] = mk(1,0,5,0,            1,0,0,3,0,                1,0,1,0,32'h1234);
      vecs[17] = mk(1,0,5,0,            1,0,0,3,0,                1,0,1,0,32'h1234);
      vecs[18] = mk(1,0,5,0,            1,0,0,3,0,                0,1,1,0,32'h1234);
      vecs[19] = mk(0,0,0,0,            0,0,0,0,0,                0,0,0,1,32'hBEEF);
      vecs[20] = mk(1,0,5,0,            0,0,1,0,0,                1,0,0,0,0);
      vecs[21] = mk(1,0,5,0,            0,0,1,0,0,                1,0,1,0,32'h1234);
      vecs[22] = mk(1,1,9,32'h55,       0,0,1,0,0,                1,0,1,0,32'h1234);
      vecs[23] = mk(1,0,9,0,            0,0,0,0,0,                1,0,0,0,0);
      vecs[24] = mk(0,0,0,0,            0,0,0,0,0,                0,0,1,0,32'h55);

      // Reset: no read returns while held.
      rst = 1'b1;
      drive(idle);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_p_rvalid", {31'd0, p_rvalid}, 32'd0);
      chk("rst_l_rvalid", {31'd0, l_rvalid}, 32'd0);
      next_cycle();
      rst = 1'b0;

      for (int i = 0; i < 25; i++) begin
         drive(vecs[i]);
         @(negedge clk);
         if (vecs[i].e_pg) begin
            ew = vecs[i].p_we; ea = vecs[i].p_addr; ed = vecs[i].p_wdata;
         end else if (vecs[i].e_lg) begin
            ew = vecs[i].l_we; ea = vecs[i].l_addr; ed = vecs[i].l_wdata;
         end else begin
            ew = 1'b0; ea = '0; ed = '0;
         end
         chk($sformatf("v%0d_p_gnt", i), {31'd0, p_gnt}, {31'd0, vecs[i].e_pg});
         chk($sformatf("v%0d_l_gnt", i), {31'd0, l_gnt}, {31'd0, vecs[i].e_lg});
         chk($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].p_req & ~vecs[i].e_pg});
         chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].e_pg | vecs[i].e_lg});
         chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, ew});
         chk($sformatf("v%0d_mem_addr", i), {22'd0, mem_addr}, {22'd0, ea});
         chk($sformatf("v%0d_mem_wdata", i), mem_wdata, ed);
         chk($sformatf("v%0d_p_rvalid", i), {31'd0, p_rvalid}, {31'd0, vecs[i].e_prv});
         chk($sformatf("v%0d_l_rvalid", i), {31'd0, l_rvalid}, {31'd0, vecs[i].e_lrv});
         if (vecs[i].e_prv) chk($sformatf("v%0d_p_rdata", i), p_rdata, vecs[i].e_rdata);
         if (vecs[i].e_lrv) chk($sformatf("v%0d_l_rdata", i), l_rdata, vecs[i].e_rdata);
         next_cycle();
      end

      // Lock burst under constant pipeline pressure. Starve guard lets the loader
      // in on cycle 4; it then holds 16 grants, yields one slot on cycle 20, and
      // the starve counter (1 after the yield) needs 3 more pipeline wins.
      rst = 1'b1;
      drive(idle);
      next_cycle();
      rst = 1'b0;
      for (int k = 0; k < 25; k++) begin
         drive(mk(1,0,5,0, 1,1,1,7,k, 0,0,0,0,0));
         @(negedge clk);
         exp_l = (k >= 4 && k <= 19) || (k == 24);
         chk($sformatf("lock%0d_l_gnt", k), {31'd0, l_gnt}, {31'd0, exp_l});
         chk($sformatf("lock%0d_p_gnt", k), {31'd0, p_gnt}, {31'd0, ~exp_l});
         chk($sformatf("lock%0d_stall", k), {31'd0, stall_o}, {31'd0, exp_l});
         next_cycle();
      end
      // Loader idles with lock held: memory stays owned, pipeline stalls.
      drive(mk(1,0,5,0, 0,0,1,0,0, 0,0,0,0,0));
      @(negedge clk);
      chk("lockhold_p_gnt", {31'd0, p_gnt}, 32'd0);
      chk("lockhold_stall", {31'd0, stall_o}, 32'd1);
      chk("lockhold_mem_en", {31'd0, mem_en}, 32'd0);
      next_cycle();
      drive(mk(1,0,5,0, 0,0,0,0,0, 0,0,0,0,0));
      @(negedge clk);
      chk("lockdrop_p_gnt", {31'd0, p_gnt}, 32'd0);
      next_cycle();
      @(negedge clk);
      chk("unlocked_p_gnt", {31'd0, p_gnt}, 32'd1);
      chk("unlocked_stall", {31'd0, stall_o}, 32'd0);
      next_cycle();

      // Reset while a loader read is in flight inside a lock.
      drive(mk(0,0,0,0, 1,0,1,5,0, 0,0,0,0,0));
      @(negedge clk);
      chk("rmr_entry_l_gnt", {31'd0, l_gnt}, 32'd1);
      next_cycle();
      @(negedge clk);
      chk("rmr_lock_l_gnt", {31'd0, l_gnt}, 32'd1);
      next_cycle();
      rst = 1'b1;
      drive(idle);
      @(negedge clk);
      chk("rmr_l_rvalid", {31'd0, l_rvalid}, 32'd0);
      next_cycle();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive(mk(1,0,5,0, 1,0,1,3,0, 0,0,0,0,0));
         @(negedge clk);
         exp_l = (k == 4);
         if (k == 0) chk("post_rst_l_rvalid", {31'd0, l_rvalid}, 32'd0);
         chk($sformatf("post_rst%0d_l_gnt", k), {31'd0, l_gnt}, {31'd0, exp_l});
         chk($sformatf("post_rst%0d_p_gnt", k), {31'd0, p_gnt}, {31'd0, ~exp_l});
         next_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
